// File: rtl/ms_timer_ctrl.sv
// ms_timer_ctrl: millisecond tick, random-wait and reaction-measurement datapath for the reaction-timer FSM
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_op    command handshake in (0 CLEAR, 1 RAND_WAIT, 2 MEASURE, 3 treated as CLEAR)
//   cmd_ready           high in IDLE and HOLD
//   abort               synchronous abort to IDLE, highest priority
//   stop_evt            single-cycle stop pulse
//   ms, rand_target     current/frozen count, latched random-wait target
//   tick, busy          1 ms pulse while busy, busy in RWAIT/MEASURE
//   done, early         completion pulse, stop-during-RWAIT pulse
//   overflow            level, set on measurement saturation
// Build option: define MS_TIMER_FAST_SIM_EN to force a 4-cycle prescaler for short simulations.
module ms_timer_ctrl #(
    parameter int          CLK_HZ       = 100000000,
    parameter int          TICK_HZ      = 1000,
    parameter int          RAND_MIN_MS  = 1000,
    parameter int          RAND_SPAN_MS = 4096,
    parameter int          MAX_MS       = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        abort,
    input  logic        stop_evt,
    output logic [15:0] ms,
    output logic [15:0] rand_target,
    output logic        tick,
    output logic        busy,
    output logic        done,
    output logic        early,
    output logic        overflow
);
`ifdef MS_TIMER_FAST_SIM_EN
    localparam int PRESCALE = 4;
`else
    localparam int PRESCALE = CLK_HZ / TICK_HZ;
`endif
    localparam int          PW   = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [15:0] MASK = 16'(RAND_SPAN_MS - 1);

    if (RAND_MIN_MS + RAND_SPAN_MS - 1 > 65535) begin : g_range_err
        $error("RAND_MIN_MS + RAND_SPAN_MS - 1 must fit in 16 bits");
    end
    if ((RAND_SPAN_MS & (RAND_SPAN_MS - 1)) != 0) begin : g_span_err
        $error("RAND_SPAN_MS must be a power of 2");
    end
    if (LFSR_SEED == 16'h0) begin : g_seed_err
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, RWAIT, MEASURE, HOLD} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc;
    logic [15:0]   lfsr, ms_nx, tgt_nx;
    logic          ovf_nx, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ms          <= '0;
            rand_target <= '0;
            overflow    <= 1'b0;
            presc       <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            state       <= state_nx;
            ms          <= ms_nx;
            rand_target <= tgt_nx;
            overflow    <= ovf_nx;
            presc       <= (abort || accept || !busy || tick) ? '0 : presc + 1'b1;
            // Galois form of x^16+x^14+x^13+x^11+1, free-running
            lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
        end
    end

    always_comb begin
        busy      = state == RWAIT || state == MEASURE;
        // an abort in the same cycle wins, so the command is not taken then
        cmd_ready = !busy && !abort;
        accept    = cmd_valid && cmd_ready;
        tick      = busy && presc == PMAX;
        state_nx  = state;
        ms_nx     = ms;
        tgt_nx    = rand_target;
        ovf_nx    = overflow;
        done      = 1'b0;
        early     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            ms_nx    = '0;
        end else if (accept) begin
            ms_nx    = '0;
            ovf_nx   = 1'b0;
            state_nx = cmd_op == 2'd1 ? RWAIT : cmd_op == 2'd2 ? MEASURE : IDLE;
            tgt_nx   = cmd_op == 2'd1 ? 16'(RAND_MIN_MS) + (lfsr & MASK) : rand_target;
        end else if (state == RWAIT) begin
            if (stop_evt) begin
                early    = 1'b1;
                state_nx = IDLE;
            end else if (tick) begin
                ms_nx    = ms + 16'd1;
                done     = ms_nx == rand_target;
                state_nx = done ? IDLE : RWAIT;
            end
        end else if (state == MEASURE) begin
            if (stop_evt) begin
                done     = 1'b1;
                state_nx = HOLD;
            end else if (tick) begin
                // saturate instead of stepping past MAX_MS
                ovf_nx   = ms >= 16'(MAX_MS);
                ms_nx    = ovf_nx ? 16'(MAX_MS) : ms + 16'd1;
                done     = ovf_nx;
                state_nx = ovf_nx ? HOLD : MEASURE;
            end
        end
    end
endmodule

// File: doc/ms_timer_ctrl.md
Name: ms_timer_ctrl

Overview:
- Sequences the millisecond timing datapath used by the reaction-timer FSM.
- Generates the 1 ms tick from clk and produces the random pre-stimulus delay from a free-running LFSR.
- Runs the up-counting reaction measurement and freezes the result for display.
- The game FSM issues commands over a valid/ready handshake and receives done/early/overflow status pulses.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- TICK_HZ, 1000, tick rate; PRESCALE = CLK_HZ/TICK_HZ cycles per ms.
- RAND_MIN_MS, 1000, minimum random wait in ms.
- RAND_SPAN_MS, 4096, random span; must be a power of 2; offset = lfsr & (RAND_SPAN_MS-1).
- MAX_MS, 9999, measurement saturation value.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 0 = CLEAR, 1 = RAND_WAIT, 2 = MEASURE, 3 = reserved (treated as CLEAR).
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- abort  in  1  synchronous abort; always honoured.
- stop_evt  in  1  single-cycle stop pulse from the button edge detector.
- ms  out  16  current or frozen millisecond count.
- rand_target  out  16  latched random-wait target.
- tick  out  1  1-cycle pulse per ms while busy.
- busy  out  1  high in RWAIT and MEASURE.
- done  out  1  1-cycle pulse on completion.
- early  out  1  1-cycle pulse when stop_evt arrives during RWAIT.
- overflow  out  1  level; set when measurement saturates, cleared by CLEAR or a new command.

Behaviour:
- Reset values (async, rst_n=0):
  - state = IDLE, ms = 0, rand_target = 0, prescaler = 0, lfsr = LFSR_SEED.
  - tick/done/early/overflow/busy = 0, cmd_ready = 1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clk regardless of state.
- Prescaler: counts 0..PRESCALE-1 only while busy. tick = 1 in the cycle it equals PRESCALE-1, then it wraps. It is cleared on every command accept, so the first tick occurs exactly PRESCALE cycles after the accept cycle.
- States: IDLE, RWAIT, MEASURE, HOLD. cmd_ready = 1 in IDLE and HOLD, 0 in RWAIT and MEASURE.
- Command accept (IDLE or HOLD):
  - CLEAR: ms = 0, overflow = 0, next state IDLE.
  - RAND_WAIT: rand_target = RAND_MIN_MS + (lfsr & (RAND_SPAN_MS-1)), using the lfsr value in the accept cycle; ms = 0, overflow = 0, next state RWAIT.
  - MEASURE: ms = 0, overflow = 0, next state MEASURE.
- RWAIT:
  - On tick, ms += 1.
  - When a tick brings ms to rand_target: done pulses in that same cycle, next state IDLE, ms keeps its value.
  - stop_evt: early pulses, next state IDLE, ms holds, no done.
- MEASURE:
  - On tick, ms += 1.
  - stop_evt: done pulses, next state HOLD, ms frozen.
  - If a tick would take ms past MAX_MS: ms = MAX_MS, overflow = 1, done pulses, next state HOLD.
- HOLD: ms frozen; stop_evt ignored.
- IDLE: stop_evt ignored.
- Priority: abort > stop_evt > tick.
  - abort: from any state go to IDLE, ms = 0, prescaler = 0, no done/early.
  - stop_evt and tick in the same cycle: stop wins, ms is not incremented.
- cmd_valid held while cmd_ready = 0 is not lost; it is accepted on the first cycle cmd_ready = 1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).
- Arithmetic: unsigned 16-bit throughout. RAND_MIN_MS + RAND_SPAN_MS - 1 must be < 65536, checked by elaboration assertion.

Optional Feature:
- MS_TIMER_FAST_SIM_EN:
  - Defined: PRESCALE is forced to 4 regardless of CLK_HZ/TICK_HZ, for short simulations.
  - Undefined: PRESCALE = CLK_HZ/TICK_HZ. All other behaviour is identical.

Test Plan (all scenarios use MS_TIMER_FAST_SIM_EN, RAND_MIN_MS=3, RAND_SPAN_MS=4, MAX_MS=9):
- Reset, then MEASURE accepted at cycle T, stop_evt at T+21 -> ticks at T+4, T+8, T+12, T+16, T+20; ms=5; done pulse at T+21; state HOLD; cmd_ready=1.
- MEASURE with no stop -> ms saturates at 9 at T+40; overflow=1; done pulse once; further ticks do not change ms.
- RAND_WAIT accept -> rand_target in [3,6]; done pulse exactly 4*rand_target cycles after accept; early never asserted.
- RAND_WAIT, stop_evt at accept+6 -> early pulse; no done; ms=1; state IDLE.
- MEASURE, abort and stop_evt in the same cycle at ms=2 -> ms=0; no done; state IDLE; busy=0.
- rst_n low mid-MEASURE at ms=3 -> outputs immediately return to reset values; lfsr=16'hACE1; cmd_ready=1.
